// File: rtl/debug_display_scanner.sv
// Debug readout for N channels onto M seven-segment digits: sequential double-dabble
// (or plain hex) conversion, sign and leading-zero handling, optional auto-stepping.
module debug_display_scanner #(
    parameter int CHANNELS    = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int DIGITS      = 6,
    parameter int CYCLE_TICKS = 45000000
) (
    input  logic                           main_clk,
    input  logic                           reset_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0] channel_data,
    input  logic [$clog2(CHANNELS)-1:0]    channel_select,
    input  logic                           hex_mode,
    input  logic                           signed_mode,
    input  logic                           auto_cycle,
    output logic [DIGITS*8-1:0]            hex_display,
    output logic [$clog2(CHANNELS)-1:0]    current_channel,
    output logic                           overflow,
    output logic                           busy
);

    localparam int CH_W  = $clog2(CHANNELS);
    // Decimal digits needed for a DATA_WIDTH-bit value (log10(2) ~ 0.30103); always >= hex nibbles
    localparam int NBCD  = (DATA_WIDTH * 30103) / 100000 + 1;
    localparam int NPAD  = (NBCD > DIGITS) ? NBCD : DIGITS;
    localparam int TMR_W = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_CONVERT,
        S_FORMAT
    } state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          bit_cnt;
    logic [TMR_W-1:0]          tmr;
    logic [CH_W-1:0]           auto_idx;
    logic [CH_W-1:0]           sel_idx;
    logic [CH_W-1:0]           ch_cap;
    logic signed [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0]     mag_in;
    logic                      neg_in;
    logic [DATA_WIDTH-1:0]     src;
    logic [NBCD*4-1:0]         digs;
    logic                      neg_cap;
    logic                      hex_cap;
    logic [DIGITS*8-1:0]       disp_nxt;
    logic                      ovf_nxt;
    logic [NPAD*4-1:0]         padded;
    int                        msd;

    function automatic logic [NBCD*4-1:0] add3_all(input logic [NBCD*4-1:0] d);
        logic [NBCD*4-1:0] r;
        r = d;
        for (int i = 0; i < NBCD; i++) begin
            if (d[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'hC0;
            4'h1: seg7 = 8'hF9;
            4'h2: seg7 = 8'hA4;
            4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;
            4'h5: seg7 = 8'h92;
            4'h6: seg7 = 8'h82;
            4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;
            4'h9: seg7 = 8'h90;
            4'hA: seg7 = 8'h88;
            4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;
            4'hD: seg7 = 8'hA1;
            4'hE: seg7 = 8'h86;
            default: seg7 = 8'h8E;
        endcase
    endfunction

    always_comb begin
        sel_idx = channel_select;
        if (auto_cycle) sel_idx = auto_idx;
        else if (int'(channel_select) >= CHANNELS) sel_idx = '0;
        word   = channel_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        neg_in = !hex_mode && signed_mode && word[DATA_WIDTH-1];
        mag_in = neg_in ? (~word + 1'b1) : word;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:    state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_CONVERT;
            S_CONVERT: if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state_nxt = S_FORMAT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        padded                = '0;
        padded[NBCD*4-1:0]    = digs;
        msd                   = 0;
        for (int i = 0; i < NBCD; i++) begin
            if (digs[i*4 +: 4] != 4'd0) msd = i;
        end
        ovf_nxt  = (msd + 1 + (neg_cap ? 1 : 0)) > DIGITS;
        disp_nxt = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (ovf_nxt)                       disp_nxt[d*8 +: 8] = 8'hBF;
            else if (d <= msd)                 disp_nxt[d*8 +: 8] = seg7(padded[d*4 +: 4]);
            else if (neg_cap && d == msd + 1)  disp_nxt[d*8 +: 8] = 8'hBF;
        end
        if (hex_cap) disp_nxt[7] = 1'b0;
    end

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            bit_cnt         <= '0;
            tmr             <= '0;
            auto_idx        <= '0;
            hex_display     <= '1;
            overflow        <= 1'b0;
            current_channel <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CAPTURE)      bit_cnt <= '0;
            else if (state == S_CONVERT) bit_cnt <= bit_cnt + 1'b1;
            if (!auto_cycle) begin
                tmr <= '0;
            end else if (tmr == TMR_W'(CYCLE_TICKS - 1)) begin
                tmr      <= '0;
                auto_idx <= (auto_idx == CH_W'(CHANNELS - 1)) ? '0 : auto_idx + 1'b1;
            end else begin
                tmr <= tmr + 1'b1;
            end
            if (state == S_FORMAT) begin
                hex_display     <= disp_nxt;
                overflow        <= ovf_nxt;
                current_channel <= ch_cap;
            end
        end
    end

    // Capture / convert datapath
    always_ff @(posedge main_clk) begin
        if (state == S_CAPTURE) begin
            src     <= mag_in;
            digs    <= '0;
            neg_cap <= neg_in;
            hex_cap <= hex_mode;
            ch_cap  <= sel_idx;
        end else if (state == S_CONVERT) begin
            src  <= {src[DATA_WIDTH-2:0], 1'b0};
            digs <= hex_cap ? {digs[NBCD*4-2:0], src[DATA_WIDTH-1]}
                            : {add3_all(digs) , 1'b0} | {{(NBCD*4-1){1'b0}}, src[DATA_WIDTH-1]};
        end
    end

endmodule

// File: tb/tb_debug_display_scanner.sv
// Bench for debug_display_scanner: a 6-digit and a 4-digit instance driven in lockstep.
module tb_debug_display_scanner;

    localparam int W = 16;
    localparam int N = 16;

    logic            main_clk = 1'b0;
    logic            reset_n;
    logic [N*W-1:0]  channel_data;
    logic [3:0]      channel_select;
    logic            hex_mode, signed_mode, auto_cycle;
    logic [47:0]     disp6;
    logic [31:0]     disp4;
    logic [3:0]      ch6, ch4;
    logic            ovf6, ovf4, busy6, busy4;

    int checks   = 0;
    int failures = 0;
    int m_tmr    = 0;
    int m_idx    = 0;

    always #5 main_clk = ~main_clk;

    debug_display_scanner #(.CHANNELS(N), .DATA_WIDTH(W), .DIGITS(6), .CYCLE_TICKS(64)) u_dut6 (
        .main_clk(main_clk), .reset_n(reset_n), .channel_data(channel_data),
        .channel_select(channel_select), .hex_mode(hex_mode), .signed_mode(signed_mode),
        .auto_cycle(auto_cycle), .hex_display(disp6), .current_channel(ch6),
        .overflow(ovf6), .busy(busy6));

    debug_display_scanner #(.CHANNELS(N), .DATA_WIDTH(W), .DIGITS(4), .CYCLE_TICKS(64)) u_dut4 (
        .main_clk(main_clk), .reset_n(reset_n), .channel_data(channel_data),
        .channel_select(channel_select), .hex_mode(hex_mode), .signed_mode(signed_mode),
        .auto_cycle(auto_cycle), .hex_display(disp4), .current_channel(ch4),
        .overflow(ovf4), .busy(busy4));

    // Reference auto-step index: timer of 64 cycles while auto_cycle is high
    always @(posedge main_clk) begin
        if (!reset_n) begin
            m_tmr <= 0;
            m_idx <= 0;
        end else if (auto_cycle) begin
            if (m_tmr == 63) begin
                m_tmr <= 0;
                m_idx <= (m_idx + 1) % N;
            end else begin
                m_tmr <= m_tmr + 1;
            end
        end else begin
            m_tmr <= 0;
        end
    end

    function automatic logic [7:0] seg7(input int n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    // Expected display for a value: bit 80 = overflow, digit d at [d*8 +: 8]
    function automatic logic [80:0] model(input logic [15:0] v, input logic hx, input logic sg, input int nd);
        logic [80:0] r;
        int mag, base, n;
        bit neg;
        int digs[$];
        r      = '1;
        r[80]  = 1'b0;
        neg    = !hx && sg && v[15];
        mag    = neg ? 65536 - int'(v) : int'(v);
        base   = hx ? 16 : 10;
        do begin
            digs.push_back(mag % base);
            mag = mag / base;
        end while (mag != 0);
        n = digs.size() + (neg ? 1 : 0);
        if (n > nd) begin
            for (int d = 0; d < nd; d++) r[d*8 +: 8] = 8'hBF;
            r[80] = 1'b1;
        end else begin
            for (int d = 0; d < digs.size(); d++) r[d*8 +: 8] = seg7(digs[d]);
            if (neg) r[digs.size()*8 +: 8] = 8'hBF;
        end
        if (hx) r[7] = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, output bit ok);
        int n;
        n = 0;
        while (busy6 !== lvl && n < 200) begin
            @(negedge main_clk);
            n++;
        end
        ok = (busy6 === lvl);
    endtask

    // Wait for a complete refresh whose capture starts after the current time
    task automatic wait_refresh(output bit ok, output int cap);
        bit a, b, c;
        wait_busy(1'b0, a);
        wait_busy(1'b1, b);
        cap = m_idx;
        wait_busy(1'b0, c);
        ok = a && b && c;
    endtask

    task automatic set_ch(input int k, input logic [15:0] v);
        channel_data[k*W +: W] = v;
    endtask

    typedef struct {
        logic [3:0]  ch;
        logic [15:0] val;
        logic        hx;
        logic        sg;
        logic [47:0] exp6;
        logic        ovf6;
        logic [31:0] exp4;
        logic        ovf4;
    } vec_t;

    vec_t        tbl [11];
    logic [80:0] r;
    bit          ok;
    int          cap, prev;
    bit          wrap;
    logic [15:0] v;

    initial begin
        tbl[0]  = '{4'd3,  16'd12345, 1'b0, 1'b0, 48'hFF_F9_A4_B0_99_92, 1'b0, 32'hBF_BF_BF_BF, 1'b1};
        tbl[1]  = '{4'd0,  16'd0,     1'b0, 1'b0, 48'hFF_FF_FF_FF_FF_C0, 1'b0, 32'hFF_FF_FF_C0, 1'b0};
        tbl[2]  = '{4'd1,  16'hBEEF,  1'b1, 1'b0, 48'hFF_FF_83_86_86_0E, 1'b0, 32'h83_86_86_0E, 1'b0};
        tbl[3]  = '{4'd5,  16'h8000,  1'b0, 1'b1, 48'hBF_B0_A4_F8_82_80, 1'b0, 32'hBF_BF_BF_BF, 1'b1};
        tbl[4]  = '{4'd7,  16'hFFFF,  1'b0, 1'b1, 48'hFF_FF_FF_FF_BF_F9, 1'b0, 32'hFF_FF_BF_F9, 1'b0};
        tbl[5]  = '{4'd4,  16'd0,     1'b1, 1'b0, 48'hFF_FF_FF_FF_FF_40, 1'b0, 32'hFF_FF_FF_40, 1'b0};
        tbl[6]  = '{4'd6,  16'hFFFF,  1'b1, 1'b1, 48'hFF_FF_8E_8E_8E_0E, 1'b0, 32'h8E_8E_8E_0E, 1'b0};
        tbl[7]  = '{4'd8,  16'd65535, 1'b0, 1'b0, 48'hFF_82_92_92_B0_92, 1'b0, 32'hBF_BF_BF_BF, 1'b1};
        tbl[8]  = '{4'd9,  16'd9999,  1'b0, 1'b0, 48'hFF_FF_90_90_90_90, 1'b0, 32'h90_90_90_90, 1'b0};
        tbl[9]  = '{4'd10, 16'hFC19,  1'b0, 1'b1, 48'hFF_FF_BF_90_90_90, 1'b0, 32'hBF_90_90_90, 1'b0};
        tbl[10] = '{4'd11, 16'hFC18,  1'b0, 1'b1, 48'hFF_BF_F9_C0_C0_C0, 1'b0, 32'hBF_BF_BF_BF, 1'b1};

        reset_n        = 1'b0;
        channel_data   = '0;
        channel_select = '0;
        hex_mode       = 1'b0;
        signed_mode    = 1'b0;
        auto_cycle     = 1'b0;
        repeat (3) @(negedge main_clk);
        chk("reset_disp6", disp6, 48'hFFFF_FFFF_FFFF);
        chk("reset_ovf6",  ovf6,  0);
        chk("reset_ch6",   ch6,   0);
        chk("reset_busy6", busy6, 0);
        reset_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < N; k++) set_ch(k, 16'($urandom));
            set_ch(tbl[i].ch, tbl[i].val);
            channel_select = tbl[i].ch;
            hex_mode       = tbl[i].hx;
            signed_mode    = tbl[i].sg;
            wait_refresh(ok, cap);
            chk("vec_timeout", ok, 1);
            chk($sformatf("vec%0d_disp6", i), disp6, tbl[i].exp6);
            chk($sformatf("vec%0d_ovf6", i),  ovf6,  tbl[i].ovf6);
            chk($sformatf("vec%0d_ch6", i),   ch6,   tbl[i].ch);
            chk($sformatf("vec%0d_disp4", i), disp4, tbl[i].exp4);
            chk($sformatf("vec%0d_ovf4", i),  ovf4,  tbl[i].ovf4);
        end

        // Random values against the reference model
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) set_ch(k, 16'($urandom));
            channel_select = 4'($urandom_range(0, N - 1));
            hex_mode       = 1'($urandom);
            signed_mode    = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: v = 16'h0000;
                    1: v = 16'h8000;
                    2: v = 16'hFFFF;
                    default: v = 16'd9999;
                endcase
                set_ch(channel_select, v);
            end
            v = channel_data[channel_select*W +: W];
            wait_refresh(ok, cap);
            chk("rnd_timeout", ok, 1);
            r = model(v, hex_mode, signed_mode, 6);
            chk("rnd_disp6", disp6, r[47:0]);
            chk("rnd_ovf6",  ovf6,  r[80]);
            chk("rnd_ch6",   ch6,   channel_select);
            r = model(v, hex_mode, signed_mode, 4);
            chk("rnd_disp4", disp4, r[31:0]);
            chk("rnd_ovf4",  ovf4,  r[80]);
        end

        // Inputs changing during CONVERT must not affect the conversion in flight
        hex_mode       = 1'b0;
        signed_mode    = 1'b0;
        channel_select = 4'd2;
        set_ch(2, 16'd4321);
        wait_refresh(ok, cap);
        wait_busy(1'b1, ok);
        @(negedge main_clk);
        @(negedge main_clk);
        set_ch(2, 16'd1111);
        hex_mode = 1'b1;
        wait_busy(1'b0, ok);
        chk("midchg_timeout", ok, 1);
        r = model(16'd4321, 1'b0, 1'b0, 6);
        chk("midchg_old", disp6, r[47:0]);
        hex_mode = 1'b0;
        wait_refresh(ok, cap);
        r = model(16'd1111, 1'b0, 1'b0, 6);
        chk("midchg_new", disp6, r[47:0]);

        // Asynchronous reset mid-CONVERT, then first-output latency
        wait_busy(1'b1, ok);
        repeat (4) @(negedge main_clk);
        reset_n = 1'b0;
        #1;
        chk("rst_disp6", disp6, 48'hFFFF_FFFF_FFFF);
        chk("rst_ch6",   ch6,   0);
        chk("rst_busy6", busy6, 0);
        chk("rst_disp4", disp4, 32'hFFFF_FFFF);
        @(negedge main_clk);
        @(negedge main_clk);
        reset_n = 1'b1;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge main_clk);
            if (k == 1)     chk("lat_busy_start", busy6, 1);
            if (k == W + 2) chk("lat_disp_early", disp6, 48'hFFFF_FFFF_FFFF);
            if (k == W + 2) chk("lat_busy_format", busy6, 1);
            if (k == W + 3) chk("lat_disp_first", disp6, r[47:0]);
            if (k == W + 3) chk("lat_ch_first", ch6, 2);
            if (k == W + 3) chk("lat_busy_end", busy6, 0);
        end

        // Auto-cycle: channel k holds k, select is ignored
        for (int k = 0; k < N; k++) set_ch(k, 16'(k));
        auto_cycle = 1'b1;
        prev = -1;
        wrap = 1'b0;
        for (int i = 0; i < 62; i++) begin
            channel_select = 4'($urandom);
            wait_refresh(ok, cap);
            chk("auto_timeout", ok, 1);
            chk("auto_ch", ch6, cap);
            r = model(16'(cap), 1'b0, 1'b0, 6);
            chk("auto_disp", disp6, r[47:0]);
            if (prev == N - 1 && cap == 0) wrap = 1'b1;
            prev = cap;
        end
        chk("auto_wrap", wrap, 1);
        auto_cycle     = 1'b0;
        channel_select = 4'd9;
        wait_refresh(ok, cap);
        chk("manual_again_ch", ch6, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
